ws2812_tx: RTL and testbench
============================

Name: ws2812_tx

Overview:
- Frame-buffer reader and line driver for WS2812 LED strings.
- Reads 24-bit GRB pixel words from the pixel RAM that the FIFO-side controller fills, using addresses 0..num_leds-1.
- Serialises each pixel MSB-first (G7..G0, R7..R0, B7..B0) onto the single-wire NRZ output, then holds the line low for the latch/reset interval.
- Sits between the pixel RAM read port and the strip data pin.

Parameters:
- T0H, 20, clk cycles dout is high for a '0' bit (400 ns at 50 MHz).
- T1H, 40, clk cycles dout is high for a '1' bit (800 ns at 50 MHz).
- T_BIT, 63, total clk cycles per bit, high plus low; must be greater than T1H.
- T_LATCH, 2500, clk cycles dout is held low after the last bit (50 us at 50 MHz).
- ADDR_WIDTH, 11, pixel RAM address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to transmit one frame.
- num_leds  in  ADDR_WIDTH  pixel count for the frame; sampled on an accepted start.
- mem_rd_en  out  1  RAM read strobe.
- mem_addr  out  ADDR_WIDTH  RAM read address.
- mem_rd_data  in  24  pixel word {G,R,B}; valid exactly 1 cycle after mem_rd_en.
- dout  out  1  WS2812 serial data line.
- busy  out  1  high from an accepted start until the latch interval ends.
- frame_done  out  1  one-cycle pulse at the end of the latch interval.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; dout=0, busy=0, frame_done=0, mem_rd_en=0, mem_addr=0; all counters and shift registers cleared.
- If reset asserts mid-frame, dout drops to 0 immediately and the frame is abandoned. No frame_done pulse.
- All outputs are registered.
- States:
  - IDLE: start=1 and num_leds!=0 → latch num_leds into pix_cnt, go to FETCH. start with num_leds=0 is ignored.
  - FETCH: mem_rd_en=1 for one cycle at mem_addr=0; go to LOAD.
  - LOAD: capture mem_rd_data into a 24-bit shift register, bit_idx=23, go to BIT.
  - BIT: counter runs 0..T_BIT-1. dout=1 while counter < (bit ? T1H : T0H), else dout=0. At counter=T_BIT-1:
    - bit_idx>0 → decrement bit_idx and shift.
    - bit_idx=0 and more pixels remain → load the prefetched pixel, stay in BIT.
    - bit_idx=0 and no pixels remain → go to LATCH.
  - LATCH: dout=0 for T_LATCH cycles. On the final cycle pulse frame_done and go to IDLE (busy falls in the same cycle).
- Prefetch:
  - On the first cycle of bit_idx=0 for pixel k (k < num_leds-1), issue mem_rd_en with mem_addr=k+1.
  - Capture the returned word into the next-pixel register on the following cycle.
  - Bit 23 of pixel k+1 starts the cycle after bit 0 of pixel k ends, so there is no gap between pixels.
- Start latency: start sampled in cycle 0 → mem_rd_en at cycle 1 → LOAD at cycle 2 → dout rises at cycle 3.
- Frame length: exactly 24·num_leds·T_BIT cycles of bit time followed by T_LATCH low cycles.
- start while busy=1 is ignored and not queued.
- num_leds changes during a frame have no effect.
- mem_addr holds its last value when mem_rd_en=0.
- mem_addr width arithmetic: pixel index counts to num_leds-1 maximum. No wrap occurs because num_leds ≤ 2^ADDR_WIDTH-1.

Optional Feature:
- Macro: WS2812_AUTO_REFRESH_EN.
- Defined: at the end of LATCH, frame_done still pulses, but the block re-samples num_leds and goes directly to FETCH (when num_leds!=0), refreshing the strip continuously. busy stays 1. start is accepted only from IDLE, which is entered after reset or when num_leds=0 at a latch end.
- Not defined: the block returns to IDLE after each frame and waits for start.

Test Plan:
- Reset values: rst_n low, then start pulsed with num_leds=1 → dout, busy and mem_rd_en stay 0. After release, all outputs are 0.
- Single pixel: num_leds=1, RAM[0]=24'hA50F00 → mem_rd_en at cycle 1, addr 0. dout shows 24 bits 1010_0101_0000_1111_0000_0000 with highs of 40/20 cycles per 63-cycle bit. Then 2500 low cycles, frame_done pulse, busy falls.
- Gap-free multi-pixel: num_leds=3, RAM={FFFFFF,000000,800001} → reads at addr 0,1,2. Total bit time exactly 72·63 cycles with no extra cycles between pixels. Bits match MSB-first order.
- Boundary: num_leds=0 with start → stays IDLE, no mem_rd_en. A start pulse during LATCH of a frame → ignored, exactly one frame_done.
- Mid-frame reset: rst_n asserted during pixel 1 bit 12 of a 3-LED frame → dout=0 asynchronously, no frame_done. A fresh start after release transmits from addr 0.
- Auto refresh (WS2812_AUTO_REFRESH_EN defined): num_leds=2, one start → frame_done pulses every 48·63+2500+3 cycles repeatedly and busy stays 1. Setting num_leds=0 → block enters IDLE after the next latch.

Source files
------------

// File: rtl/ws2812_tx_if.sv
// Pixel RAM read port, frame control and strip line of the WS2812 transmitter.
// master = transmitter side, slave = controller/RAM/strip side.
interface ws2812_tx_if #(
    parameter int ADDR_WIDTH = 11
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] num_leds;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [23:0]           mem_rd_data;
    logic                  dout;
    logic                  busy;
    logic                  frame_done;

    modport master (
        input  start, num_leds, mem_rd_data,
        output mem_rd_en, mem_addr, dout, busy, frame_done
    );

    modport slave (
        output start, num_leds, mem_rd_data,
        input  mem_rd_en, mem_addr, dout, busy, frame_done
    );
endinterface

// File: rtl/ws2812_tx.sv
// WS2812 frame transmitter: fetches GRB words from pixel RAM and drives the NRZ line.
// Optional WS2812_AUTO_REFRESH_EN: restart the frame after every latch while num_leds != 0.
module ws2812_tx #(
    parameter int T0H        = 20,
    parameter int T1H        = 40,
    parameter int T_BIT      = 63,
    parameter int T_LATCH    = 2500,
    parameter int ADDR_WIDTH = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    ws2812_tx_if.master bus
);
    localparam int CNT_MAX = (T_LATCH > T_BIT) ? T_LATCH : T_BIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] C_T0H      = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] C_T1H      = CNT_W'(T1H);
    localparam logic [CNT_W-1:0] C_BIT_LAST = CNT_W'(T_BIT - 1);
    localparam logic [CNT_W-1:0] C_LAT_LAST = CNT_W'(T_LATCH - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_BIT, S_LATCH} state_t;

    state_t                r_state, w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [4:0]            r_bit_idx;
    logic [23:0]           r_shreg, r_next_pix;
    logic [ADDR_WIDTH-1:0] r_pix_cnt, r_pix_idx, r_mem_addr;
    logic                  r_rd_pend, r_mem_rd_en, r_dout, r_busy, r_frame_done;

    logic                  w_accept, w_go, w_busy_after, w_cnt_last, w_lat_last, w_more;
    logic [CNT_W-1:0]      w_thr;
    logic                  w_dout_d, w_busy_d, w_done_d, w_rd_en_d;
    logic [ADDR_WIDTH-1:0] w_addr_d;

    assign w_accept   = bus.start && (bus.num_leds != '0);
    assign w_cnt_last = (r_cnt == C_BIT_LAST);
    assign w_lat_last = (r_cnt == C_LAT_LAST);
    assign w_more     = (r_pix_idx != (r_pix_cnt - ADDR_WIDTH'(1)));
    assign w_thr      = r_shreg[23] ? C_T1H : C_T0H;

`ifdef WS2812_AUTO_REFRESH_EN
    // busy still high in IDLE means the previous latch ended with a refresh pending
    assign w_go         = r_busy || w_accept;
    assign w_busy_after = (bus.num_leds != '0);
`else
    assign w_go         = w_accept;
    assign w_busy_after = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_go) w_next = S_FETCH;
            S_FETCH: w_next = S_LOAD;
            S_LOAD:  w_next = S_BIT;
            S_BIT:   if (w_cnt_last && (r_bit_idx == 5'd0) && !w_more) w_next = S_LATCH;
            S_LATCH: if (w_lat_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are registered, so this computes the value each one takes next cycle.
    always_comb begin
        w_dout_d  = 1'b0;
        w_busy_d  = r_busy;
        w_done_d  = 1'b0;
        w_rd_en_d = 1'b0;
        w_addr_d  = r_mem_addr;
        case (r_state)
            S_IDLE: if (w_go) begin
                w_busy_d  = 1'b1;
                w_rd_en_d = 1'b1;
                w_addr_d  = '0;
            end
            S_LOAD: w_dout_d = 1'b1;
            S_BIT: begin
                if (!w_cnt_last) begin
                    w_dout_d = (r_cnt + CNT_W'(1)) < w_thr;
                end else begin
                    w_dout_d = (r_bit_idx != 5'd0) || w_more;
                    // prefetch so the word is ready by the end of bit 0
                    if ((r_bit_idx == 5'd1) && w_more) begin
                        w_rd_en_d = 1'b1;
                        w_addr_d  = r_pix_idx + ADDR_WIDTH'(1);
                    end
                end
            end
            S_LATCH: if (w_lat_last) begin
                w_done_d = 1'b1;
                w_busy_d = w_busy_after;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shreg      <= '0;
            r_next_pix   <= '0;
            r_pix_cnt    <= '0;
            r_pix_idx    <= '0;
            r_rd_pend    <= 1'b0;
            r_mem_rd_en  <= 1'b0;
            r_mem_addr   <= '0;
            r_dout       <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_dout       <= w_dout_d;
            r_busy       <= w_busy_d;
            r_frame_done <= w_done_d;
            r_mem_rd_en  <= w_rd_en_d;
            r_mem_addr   <= w_addr_d;
            r_rd_pend    <= r_mem_rd_en;
            if (r_rd_pend && (r_state == S_BIT)) r_next_pix <= bus.mem_rd_data;
            case (r_state)
                S_IDLE: if (w_go) begin
                    r_pix_idx <= '0;
                    if (w_accept && !r_busy) r_pix_cnt <= bus.num_leds;
                end
                S_LOAD: begin
                    r_shreg   <= bus.mem_rd_data;
                    r_bit_idx <= 5'd23;
                    r_cnt     <= '0;
                end
                S_BIT: begin
                    if (w_cnt_last) begin
                        r_cnt <= '0;
                        if (r_bit_idx != 5'd0) begin
                            r_bit_idx <= r_bit_idx - 5'd1;
                            r_shreg   <= {r_shreg[22:0], 1'b0};
                        end else if (w_more) begin
                            r_shreg   <= r_next_pix;
                            r_bit_idx <= 5'd23;
                            r_pix_idx <= r_pix_idx + ADDR_WIDTH'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_LATCH: begin
                    if (w_lat_last) begin
                        r_cnt     <= '0;
                        r_pix_cnt <= bus.num_leds;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dout       = r_dout;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
    assign bus.mem_rd_en  = r_mem_rd_en;
    assign bus.mem_addr   = r_mem_addr;
endmodule

// File: tb/tb_ws2812_tx.sv
// Bench for ws2812_tx: frame-level timing model checked every cycle plus literal per-frame totals.
module tb_ws2812_tx;
    localparam int T0H = 20, T1H = 40, T_BIT = 63, T_LATCH = 2500, AW = 11;
`ifdef WS2812_AUTO_REFRESH_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ws2812_tx_if #(.ADDR_WIDTH(AW)) bus ();

    ws2812_tx #(.T0H(T0H), .T1H(T1H), .T_BIT(T_BIT), .T_LATCH(T_LATCH), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    logic [23:0] ram [0:7];
    int checks = 0, failures = 0;
    int cyc = 0, s_cyc = 0;
    int hi_cnt, rise_cnt, rd_cnt, done_cnt, done_t, done_c;
    logic prev_dout = 1'b0;

    // frame model: m_t = cycles since the accepted start (-1 when idle)
    int m_t = -1, m_nl = 0, m_nxt = 0, m_end = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (bus.mem_rd_en === 1'b1) bus.mem_rd_data <= ram[bus.mem_addr[2:0]];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = -1;
        end else if (m_t < 0 || m_t == m_end) begin
            if (AUTO && m_t == m_end && m_nxt != 0) begin
                m_nl = m_nxt; m_t = 1;
            end else if (bus.start && bus.num_leds != 0) begin
                m_nl = int'(bus.num_leds); m_t = 1;
            end else begin
                m_t = -1;
            end
        end else begin
            if (m_t == m_end - 1) m_nxt = int'(bus.num_leds);
            m_t++;
        end
        m_end = 3 + 24 * m_nl * T_BIT + T_LATCH;
    end

    always @(negedge clk) begin : cmp
        int u, i, p, b;
        logic [23:0] pix;
        logic e_dout, e_busy, e_done, e_rd;
        int e_addr;
        e_dout = 0; e_busy = 0; e_done = 0; e_rd = 0; e_addr = 0;
        if (m_t >= 1) begin
            u = m_t - 3;
            if (u >= 0 && u < 24 * m_nl * T_BIT) begin
                i = u / T_BIT; p = i / 24; b = 23 - (i % 24);
                pix = ram[p];
                e_dout = (u % T_BIT) < (pix[b] ? T1H : T0H);
                if ((i % 24) == 23 && (u % T_BIT) == 0 && p + 1 < m_nl) begin
                    e_rd = 1; e_addr = p + 1;
                end
            end
            if (m_t == 1) e_rd = 1;
            e_busy = (m_t < m_end) || (AUTO && m_nxt != 0);
            e_done = (m_t == m_end);
        end
        chk("dout", 32'(bus.dout), 32'(e_dout));
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("frame_done", 32'(bus.frame_done), 32'(e_done));
        chk("mem_rd_en", 32'(bus.mem_rd_en), 32'(e_rd));
        if (e_rd) chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    end

    always @(negedge clk) begin
        if (bus.dout === 1'b1) begin
            hi_cnt++;
            if (prev_dout !== 1'b1) rise_cnt++;
        end
        prev_dout = bus.dout;
        if (bus.mem_rd_en === 1'b1) rd_cnt++;
        if (bus.frame_done === 1'b1) begin
            done_cnt++; done_t = cyc - s_cyc; done_c = cyc;
        end
    end

    task automatic do_start(input int nl);
        @(negedge clk);
        bus.num_leds = AW'(nl); bus.start = 1'b1; s_cyc = cyc;
        hi_cnt = 0; rise_cnt = 0; rd_cnt = 0; done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b0; bus.num_leds = '0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        do begin
            @(negedge clk); n++;
        end while (bus.frame_done !== 1'b1 && n < budget);
        #1;
        chk({"timeout_", nm}, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c1, rd0;
        bus.start = 1'b0; bus.num_leds = '0; bus.mem_rd_data = '0;
        foreach (ram[k]) ram[k] = '0;

        // start pulses while held in reset must do nothing
        repeat (3) begin
            @(negedge clk); bus.start = 1'b1; bus.num_leds = AW'(1);
            @(negedge clk); bus.start = 1'b0;
        end
        bus.num_leds = '0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_dout", 32'(bus.dout), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.frame_done), 0);
        chk("rst_rd_en", 32'(bus.mem_rd_en), 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);

        // single pixel: 8 ones, 16 zeros
        ram[0] = 24'hA50F00;
        do_start(1);
        wait_done(6000, "single");
        chk("single_done_t", done_t, 3 + 24 * 63 + 2500);
        chk("single_hi", hi_cnt, 8 * 40 + 16 * 20);
        chk("single_rise", rise_cnt, 24);
        chk("single_rd", rd_cnt, 1);
        chk("single_busy_end", 32'(bus.busy), 0);

        // three pixels back to back: 26 ones, 46 zeros
        ram[0] = 24'hFFFFFF; ram[1] = 24'h000000; ram[2] = 24'h800001;
        do_start(3);
        wait_done(9000, "three");
        chk("three_done_t", done_t, 3 + 72 * 63 + 2500);
        chk("three_hi", hi_cnt, 26 * 40 + 46 * 20);
        chk("three_rise", rise_cnt, 72);
        chk("three_rd", rd_cnt, 3);

        // num_leds = 0 is ignored
        do_start(0);
        repeat (20) @(negedge clk);
        #1;
        chk("zero_rd", rd_cnt, 0);
        chk("zero_busy", 32'(bus.busy), 0);

        // start during the latch interval is dropped
        ram[0] = 24'hA50F00;
        do_start(1);
        repeat (2999) @(negedge clk);
        bus.start = 1'b1; bus.num_leds = AW'(2);
        @(negedge clk);
        bus.start = 1'b0; bus.num_leds = '0;
        wait_done(6000, "latch_start");
        repeat (200) @(negedge clk);
        #1;
        chk("latch_start_done_cnt", done_cnt, 1);
        chk("latch_start_rd", rd_cnt, 1);
        chk("latch_start_busy", 32'(bus.busy), 0);

        // reset during pixel 1 bit 12, inside the high phase
        ram[0] = 24'hFFFFFF; ram[1] = 24'h000000; ram[2] = 24'h800001;
        do_start(3);
        repeat (2217) @(negedge clk);
        #1;
        chk("pre_reset_dout", 32'(bus.dout), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_dout", 32'(bus.dout), 0);
        chk("async_reset_busy", 32'(bus.busy), 0);
        repeat (10) @(negedge clk);
        #1;
        chk("reset_no_done", done_cnt, 0);
        @(negedge clk); rst_n = 1'b1;
        do_start(3);
        wait_done(9000, "after_reset");
        chk("after_reset_done_t", done_t, 3 + 72 * 63 + 2500);
        chk("after_reset_hi", hi_cnt, 26 * 40 + 46 * 20);
        chk("after_reset_done_cnt", done_cnt, 1);

`ifdef WS2812_AUTO_REFRESH_EN
        do_start(2);
        bus.num_leds = AW'(2);
        wait_done(7000, "auto1");
        chk("auto_first_done_t", done_t, 48 * 63 + 2500 + 3);
        chk("auto_busy_held", 32'(bus.busy), 1);
        c1 = done_c;
        wait_done(7000, "auto2");
        chk("auto_period", done_c - c1, 48 * 63 + 2500 + 3);
        bus.num_leds = '0;
        wait_done(7000, "auto3");
        chk("auto_stop_busy", 32'(bus.busy), 0);
        rd0 = rd_cnt;
        repeat (100) @(negedge clk);
        #1;
        chk("auto_stop_rd", rd_cnt, rd0);
`else
        c1 = 0; rd0 = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
